serial_tx_arbiter: RTL and testbench

- Shares one sendFrame serializer between N_REQ requesters, each submitting a WORDS-word frame.
- Round-robin arbitration; snapshots the winning frame into a local buffer and pulses the serializer start.
- Serves the serializer's per-word index reads from the buffer.
- Returns a one-cycle done pulse to the requester when the serializer reports ready again.

---
 rtl/serial_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_serial_tx_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one frame serializer among N_REQ requesters.
// Define SERIAL_TX_ARBITER_BACK_TO_BACK_EN to re-arbitrate in the finishing SEND cycle.
module serial_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int WORD_WIDTH  = 8,
  parameter int WORDS       = 2,
  parameter int INDEX_WIDTH = 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [N_REQ-1:0]                  req,
  input  logic [N_REQ*WORDS*WORD_WIDTH-1:0] reqData,
  output logic [N_REQ-1:0]                  grant,
  output logic [N_REQ-1:0]                  done,
  output logic                              busy,
  output logic                              frameStart,
  input  logic [INDEX_WIDTH-1:0]            frameIndex,
  output logic [WORD_WIDTH-1:0]             frameWord,
  input  logic                              frameReadyAtNext
);

  localparam int FW = WORDS * WORD_WIDTH;
  localparam int PW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_START, S_SEND} state_t;

  state_t           r_state, w_state_nx;
  logic [N_REQ-1:0] r_grant, w_grant_nx;
  logic [N_REQ-1:0] r_done, w_done_nx;
  logic             r_start, w_start_nx;
  logic             r_busy;
  logic [PW-1:0]    r_ptr, w_ptr_nx;
  logic [PW-1:0]    r_win, w_win_nx;
  logic [FW-1:0]    r_buf, w_buf_nx;
  logic [PW:0]      w_pick_idle;

  // Returns {found, index} of the first eligible bit at or after ptr, wrapping.
  function automatic logic [PW:0] rr_pick(input logic [N_REQ-1:0] elig,
                                          input logic [PW-1:0]    ptr);
    logic          found;
    logic [PW-1:0] idx;
    int            p;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      p = int'(ptr) + k;
      if (p >= N_REQ) p = p - N_REQ;
      if (!found && elig[p]) begin
        found = 1'b1;
        idx   = PW'(p);
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] w);
    return (int'(w) == N_REQ - 1) ? '0 : w + PW'(1);
  endfunction

  // A requester whose done is pulsing this cycle sits out this arbitration.
  assign w_pick_idle = rr_pick(req & ~r_done, r_ptr);

`ifdef SERIAL_TX_ARBITER_BACK_TO_BACK_EN
  logic [PW:0] w_pick_b2b;
  assign w_pick_b2b = rr_pick(req & ~(ONE << r_win), ptr_after(r_win));
`endif

  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_done_nx  = '0;
    w_start_nx = 1'b0;
    w_ptr_nx   = r_ptr;
    w_win_nx   = r_win;
    w_buf_nx   = r_buf;
    case (r_state)
      S_INIT: if (frameReadyAtNext) w_state_nx = S_IDLE;
      S_IDLE: begin
        if (w_pick_idle[PW]) begin
          w_state_nx = S_START;
          w_win_nx   = w_pick_idle[PW-1:0];
          w_grant_nx = ONE << w_pick_idle[PW-1:0];
          w_buf_nx   = reqData[int'(w_pick_idle[PW-1:0])*FW +: FW];
          w_start_nx = 1'b1;
        end
      end
      S_START: w_state_nx = S_SEND;
      S_SEND: begin
        if (frameReadyAtNext) begin
          w_state_nx = S_IDLE;
          w_grant_nx = '0;
          w_done_nx  = ONE << r_win;
          w_ptr_nx   = ptr_after(r_win);
`ifdef SERIAL_TX_ARBITER_BACK_TO_BACK_EN
          if (w_pick_b2b[PW]) begin
            w_state_nx = S_START;
            w_win_nx   = w_pick_b2b[PW-1:0];
            w_grant_nx = ONE << w_pick_b2b[PW-1:0];
            w_buf_nx   = reqData[int'(w_pick_b2b[PW-1:0])*FW +: FW];
            w_start_nx = 1'b1;
          end
`endif
        end
      end
      default: w_state_nx = S_INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_INIT;
      r_grant <= '0;
      r_done  <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b1;
      r_ptr   <= '0;
      r_win   <= '0;
      r_buf   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_grant <= w_grant_nx;
      r_done  <= w_done_nx;
      r_start <= w_start_nx;
      r_busy  <= (w_state_nx != S_IDLE);
      r_ptr   <= w_ptr_nx;
      r_win   <= w_win_nx;
      r_buf   <= w_buf_nx;
    end
  end

  // Out-of-range indices fall through to zero.
  always_comb begin
    frameWord = '0;
    for (int k = 0; k < WORDS; k++)
      if (int'(frameIndex) == k) frameWord = r_buf[k*WORD_WIDTH +: WORD_WIDTH];
  end

  assign grant      = r_grant;
  assign done       = r_done;
  assign busy       = r_busy;
  assign frameStart = r_start;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter with a small behavioural serializer.
module tb_serial_tx_arbiter;

  localparam int N  = 4;
  localparam int WW = 8;
  localparam int WD = 2;
  localparam int IW = 1;
  localparam int FW = WD * WW;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*FW-1:0] reqData;
  logic [N-1:0]    grant, done;
  logic            busy, frameStart;
  logic [IW-1:0]   frameIndex;
  logic [WW-1:0]   frameWord;
  logic            frameReadyAtNext;

  serial_tx_arbiter #(.N_REQ(N), .WORD_WIDTH(WW), .WORDS(WD), .INDEX_WIDTH(IW)) dut (
    .clock(clock), .reset(reset), .req(req), .reqData(reqData),
    .grant(grant), .done(done), .busy(busy), .frameStart(frameStart),
    .frameIndex(frameIndex), .frameWord(frameWord), .frameReadyAtNext(frameReadyAtNext)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int ser_cnt  = 0;
  bit ser_hold = 0;
  bit auto_drop = 0;
  logic [N-1:0]  prev_done = '0;
  logic [FW-1:0] rx_cur;
  logic [FW-1:0] rx_q[$];
  logic [N-1:0]  start_g_q[$];
  int            start_c_q[$];
  int            done_c_q[$];
  logic [N-1:0]  done_g_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: advance, run the serializer model, watch outputs.
  task automatic tick();
    @(posedge clock); #1; cyc++;
    if (ser_cnt > 0) begin
      frameIndex = IW'(WD - ser_cnt);
      #1;
      rx_cur[(WD-ser_cnt)*WW +: WW] = frameWord;
      ser_cnt--;
      if (ser_cnt == 0) begin
        rx_q.push_back(rx_cur);
        frameReadyAtNext = !ser_hold;
      end
    end else #1;
    if (frameStart) begin
      start_g_q.push_back(grant);
      start_c_q.push_back(cyc);
      frameReadyAtNext = 1'b0;
      ser_cnt = WD;
    end
    if (done != '0) begin
      chk("done_single_cycle", 32'(done & prev_done), 0);
      chk("no_regrant_in_done", 32'(grant & done), 0);
      done_c_q.push_back(cyc);
      done_g_q.push_back(done);
      if (auto_drop) req = req & ~done;
    end
    if (grant != '0) chk("grant_onehot", $countones(grant), 1);
    prev_done = done;
  endtask

  task automatic clear_logs();
    rx_q.delete(); start_g_q.delete(); start_c_q.delete();
    done_c_q.delete(); done_g_q.delete();
  endtask

  task automatic reset_dut();
    reset = 1'b1; req = '0; ser_hold = 0; ser_cnt = 0;
    frameReadyAtNext = 1'b1; frameIndex = '0; auto_drop = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    clear_logs();
  endtask

  task automatic run_starts(input int n, input int budget);
    for (int i = 0; i < budget && start_g_q.size() < n; i++) tick();
    chk("starts_seen", 32'(start_g_q.size() >= n), 1);
  endtask

  task automatic run_dones(input int n, input int budget);
    for (int i = 0; i < budget && done_c_q.size() < n; i++) tick();
    chk("dones_seen", 32'(done_c_q.size() >= n), 1);
  endtask

  initial begin
    int rc;
    int n0;
    int exp_gap;
    logic [N-1:0] exp_rr[8];

    // Reset state
    reset = 1'b1; req = '0; reqData = '0; frameIndex = '0; frameReadyAtNext = 1'b1;
    repeat (3) tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_start", 32'(frameStart), 0);
    chk("rst_busy", 32'(busy), 1);
    reset = 1'b0;
    repeat (2) tick();
    chk("idle_busy", 32'(busy), 0);
    clear_logs();

    // Single frame
    reqData = 64'hDD44_CC33_BB22_76A5;
    auto_drop = 1; req = 4'b0001;
    run_dones(1, 30);
    repeat (4) tick();
    chk("sf_starts", start_g_q.size(), 1);
    chk("sf_grant", 32'(start_g_q[0]), 32'h1);
    chk("sf_word0", 32'(rx_q[0][7:0]), 32'hA5);
    chk("sf_word1", 32'(rx_q[0][15:8]), 32'h76);
    chk("sf_frame", 32'(rx_q[0]), 32'h76A5);
    chk("sf_done_who", 32'(done_g_q[0]), 32'h1);
    chk("sf_done_lat", done_c_q[0] - start_c_q[0], 3);
    chk("sf_grant_off", 32'(grant), 0);

    // Round-robin, each holder drops after its done
    reqData = 64'hDD44_CC33_BB22_AA11;
    reset_dut();
    auto_drop = 1; req = 4'b1011;
    run_dones(3, 60);
    repeat (4) tick();
    chk("rr_starts", start_g_q.size(), 3);
    chk("rr_g0", 32'(start_g_q[0]), 32'h1);
    chk("rr_g1", 32'(start_g_q[1]), 32'h2);
    chk("rr_g2", 32'(start_g_q[2]), 32'h8);
    chk("rr_d0", 32'(rx_q[0]), 32'hAA11);
    chk("rr_d1", 32'(rx_q[1]), 32'hBB22);
    chk("rr_d2", 32'(rx_q[2]), 32'hDD44);
    chk("rr_idle", 32'(grant), 0);

    // Fairness, all held
    reset_dut();
    req = 4'b1111;
    run_starts(8, 200);
    exp_rr = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    for (int i = 0; i < 8; i++) chk($sformatf("fair_g%0d", i), 32'(start_g_q[i]), 32'(exp_rr[i]));
    exp_gap = 4;
`ifdef SERIAL_TX_ARBITER_BACK_TO_BACK_EN
    exp_gap = 3;
`endif
    chk("fair_gap", start_c_q[1] - start_c_q[0], exp_gap);
    req = '0;
    run_dones(8, 40);

    // Snapshot: source changes while the frame is in flight
    reqData = 64'hDD44_CC33_BB22_1234;
    reset_dut();
    req = 4'b0001;
    run_starts(1, 20);
    reqData[15:0] = 16'hFFFF;
    run_dones(1, 20);
    chk("snap_frame", 32'(rx_q[0]), 32'h1234);
    req = '0;
    repeat (3) tick();

    // Single requester continuously re-requesting
    reqData = 64'hDD44_CC33_BB22_AA11;
    reset_dut();
    req = 4'b0001;
    run_starts(3, 60);
    chk("solo_g2", 32'(start_g_q[2]), 32'h1);
    chk("solo_gap1", start_c_q[1] - start_c_q[0], 5);
    chk("solo_gap2", start_c_q[2] - start_c_q[1], 5);
    req = '0;
    run_dones(3, 20);

    // Back-to-back: start for requester 1 relative to done[0]
    reset_dut();
    req = 4'b0011;
    run_starts(2, 40);
    exp_gap = 1;
`ifdef SERIAL_TX_ARBITER_BACK_TO_BACK_EN
    exp_gap = 0;
`endif
    chk("b2b_g1", 32'(start_g_q[1]), 32'h2);
    chk("b2b_gap", start_c_q[1] - done_c_q[0], exp_gap);
    req = '0;
    run_dones(2, 20);

    // Reset in SEND with serializer held not-ready
    reset_dut();
    req = 4'b0001;
    run_starts(1, 20);
    tick();
    ser_hold = 1; ser_cnt = 0; frameReadyAtNext = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n0 = start_g_q.size();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mr_grant", 32'(grant), 0);
      chk("mr_done", 32'(done), 0);
      chk("mr_start", 32'(frameStart), 0);
      chk("mr_busy", 32'(busy), 1);
    end
    chk("mr_no_start", start_g_q.size(), n0);
    ser_hold = 0; frameReadyAtNext = 1'b1;
    rc = cyc;
    run_starts(n0 + 1, 20);
    chk("mr_first_start", start_c_q[n0] - rc, 2);
    req = '0;
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
